flit_sender: RTL
================

FLIT_SENDER -- requirements
Module: flit_sender

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits including type field.
REQ-002 Parameter TYPE_WIDTH, default 2, flit type field width, occupying bits [DATA_WIDTH-1 -: TYPE_WIDTH].
REQ-003 Parameter COUNT_WIDTH, default 8, width of per-packet flit counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 fifo_empty  input  1  upstream buffer empty flag.
REQ-007 fifo_rd_en  output  1  pop request to upstream buffer.
REQ-008 fifo_dout  input  DATA_WIDTH  upstream head-of-buffer flit, first-word-fall-through (valid whenever fifo_empty=0).
REQ-009 data_out  output  DATA_WIDTH  registered flit to link.
REQ-010 valid_out  output  1  data_out holds a flit.
REQ-011 ready_in  input  1  link accepts flit this cycle.
REQ-012 pkt_active  output  1  a packet has been started but its tail not yet popped.
REQ-013 flit_count  output  COUNT_WIDTH  flits popped in current packet.
REQ-014 error  output  1  sticky protocol-violation flag.

Function
REQ-015 Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11.
REQ-016 fifo_rd_en SHALL be combinational: ~fifo_empty & (~valid_out | ready_in); never asserted while rst low.
REQ-017 On a cycle with fifo_rd_en=1, data_out SHALL load fifo_dout and valid_out SHALL be 1 next cycle (latency one cycle pop-to-valid).
REQ-018 On ready_in=1 & valid_out=1 with no pop, valid_out SHALL clear next cycle; data_out holds its value.
REQ-019 Simultaneous accept and pop SHALL replace data_out with no bubble; sustained throughput one flit per cycle.
REQ-020 While valid_out=1 & ready_in=0, data_out and valid_out SHALL be held stable.
REQ-021 FSM states IDLE, PACKET; reset state IDLE.
REQ-022 IDLE: popping HEAD -> PACKET, flit_count=1; popping SINGLE -> stays IDLE, flit_count=1.
REQ-023 PACKET: popping BODY -> stays, flit_count increments; popping TAIL -> IDLE, flit_count increments.
REQ-024 flit_count SHALL hold its last value in IDLE until the next packet's first pop, and SHALL saturate at all-ones (no wrap).
REQ-025 pkt_active SHALL equal (state==PACKET).
REQ-026 Out-of-sequence flits (BODY/TAIL in IDLE, HEAD/SINGLE in PACKET) SHALL still be forwarded; FSM treats HEAD/SINGLE as new packet start, BODY/TAIL in IDLE leaves state IDLE.

Reset
REQ-027 rst low SHALL immediately force data_out=0, valid_out=0, state IDLE, flit_count=0, error=0, regardless of clk.
REQ-028 Reset asserted mid-packet SHALL discard the in-flight output flit; no partial-packet recovery is performed.

Configuration
REQ-029 Macro FLIT_SENDER_PKT_CHECK_EN defined: error SHALL set one cycle after any out-of-sequence pop per REQ-026 and stay set until reset.
REQ-030 Macro undefined: error SHALL be tied 0 and no checking logic SHALL be synthesised; all other behaviour identical.

Structure
REQ-031 Flit type enum, type-field constants and the FSM state enum SHALL live in a shared package noc_pkg, reused by the matching receive-side blocks.
REQ-032 The block SHALL be a single module; no sub-module.

Verification
REQ-033 Pop timing: FIFO holds HEAD(0x8000_0001), BODY, TAIL, ready_in=1 constant -> valid_out high 3 consecutive cycles from the cycle after first pop, flit_count 1,2,3, pkt_active 1,1,0.
REQ-034 Backpressure: ready_in=0 for 4 cycles with valid_out=1 -> fifo_rd_en=0 and data_out stable all 4 cycles; ready_in=1 resumes with no lost or duplicated flit.
REQ-035 Empty boundary: fifo_empty=1 throughout -> fifo_rd_en=0, valid_out drops after last accept, state unchanged.
REQ-036 SINGLE flit 0xC000_0005 in IDLE -> forwarded, flit_count=1, pkt_active stays 0.
REQ-037 With FLIT_SENDER_PKT_CHECK_EN: BODY popped in IDLE -> flit forwarded, error=1 next cycle and held; without macro, error stays 0.
REQ-038 rst low mid-packet (after HEAD, BODY) -> valid_out=0, flit_count=0, pkt_active=0 asynchronously; next HEAD after release restarts count at 1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit type encoding and packet-framing FSM states,
// common to the send- and receive-side link blocks.
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } pkt_state_e;

  // HEAD and SINGLE both open a new packet; BODY and TAIL only continue one.
  function automatic logic is_pkt_start(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/flit_sender.sv
// Pops flits from a FWFT buffer into a one-deep registered link stage and tracks packet framing.
// Define FLIT_SENDER_PKT_CHECK_EN to build the sticky out-of-sequence error detector.
module flit_sender
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TYPE_WIDTH  = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   pkt_active,
  output logic [COUNT_WIDTH-1:0] flit_count,
  output logic                   error
);

  pkt_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q,  data_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [TYPE_WIDTH-1:0]  type_field;
  flit_type_e             ftype;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign type_field = fifo_dout[DATA_WIDTH-1 -: TYPE_WIDTH];
  assign ftype      = flit_type_e'(type_field[TYPE_WIDTH-1 -: FLIT_TYPE_W]);

  // Pop whenever the output stage is empty or being drained this cycle.
  assign fifo_rd_en = rst & ~fifo_empty & (~valid_q | ready_in);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (fifo_rd_en) begin
      data_d  = fifo_dout;
      valid_d = 1'b1;
      case (ftype)
        FLIT_HEAD: begin
          state_d = ST_PACKET;
          count_d = COUNT_WIDTH'(1);
        end
        FLIT_SINGLE: begin
          state_d = ST_IDLE;
          count_d = COUNT_WIDTH'(1);
        end
        default: begin
          // Stray BODY/TAIL in IDLE is forwarded but does not touch framing state.
          if (state_q == ST_PACKET) begin
            count_d = sat_inc(count_q);
            if (ftype == FLIT_TAIL) state_d = ST_IDLE;
          end
        end
      endcase
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign flit_count = count_q;
  assign pkt_active = (state_q == ST_PACKET);

`ifdef FLIT_SENDER_PKT_CHECK_EN
  logic oos;
  logic err_q, err_d;

  // Out of sequence: a packet start while in PACKET, or a continuation while IDLE.
  assign oos   = fifo_rd_en & (is_pkt_start(ftype) == (state_q == ST_PACKET));
  assign err_d = err_q | oos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule
